// File: rtl/hwpe_stream_streamer_queue_mc.sv
// Purpose : per-channel ctrl/flags queues between a controller and its streamers, with
//           outstanding-credit accounting, idle detection and sticky underflow flag.
// Latency : one cycle through each FIFO (pushed at edge N, visible on pop side at N+1).
// Backpr. : push ready = FIFO not-full (ctrl side also gated by credit); never depends on pop ready.
// Ports   : clk_i/rst_i/clear_i; ctrl_* controller->queue; streamer_ctrl_* queue->streamer;
//           streamer_flags_* streamer->queue; flags_* queue->controller;
//           outstanding_o/idle_o/underflow_o per-channel status, channel c packed at slice c.

// Generic circular-buffer FIFO used for both directions of every channel.
module hwpe_stream_streamer_queue_mc_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clear_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             push_valid_i,
   output logic             push_ready_o,
   output logic [WIDTH-1:0] pop_data_o,
   output logic             pop_valid_o,
   input  logic             pop_ready_i
);
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             push_ok, pop_ok;

   assign push_ready_o = (cnt_q != CW'(DEPTH));
   assign pop_valid_o  = (cnt_q != '0);
   assign pop_data_o   = mem_q[rd_q];
   assign push_ok      = push_valid_i && push_ready_o;
   assign pop_ok       = pop_ready_i && pop_valid_o;

   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q + CW'(push_ok) - CW'(pop_ok);
      if (push_ok) begin
         wr_d = (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + PW'(1);
      end
      if (pop_ok) begin
         rd_d = (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + PW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   // Storage is not reset: entries are only observable while counted as valid.
   always_ff @(posedge clk_i) begin
      if (push_ok && !(rst_i || clear_i)) begin
         mem_q[wr_q] <= push_data_i;
      end
   end
endmodule

module hwpe_stream_streamer_queue_mc #(
   parameter int unsigned NB_CHANNELS     = 2,
   parameter int unsigned CTRL_WIDTH      = 64,
   parameter int unsigned FLAGS_WIDTH     = 32,
   parameter int unsigned FIFO_DEPTH      = 2,
   parameter int unsigned MAX_OUTSTANDING = 4,
   localparam int unsigned CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic                               clear_i,
   input  logic [NB_CHANNELS*CTRL_WIDTH-1:0]  ctrl_data_i,
   input  logic [NB_CHANNELS-1:0]             ctrl_valid_i,
   output logic [NB_CHANNELS-1:0]             ctrl_ready_o,
   output logic [NB_CHANNELS*CTRL_WIDTH-1:0]  streamer_ctrl_data_o,
   output logic [NB_CHANNELS-1:0]             streamer_ctrl_valid_o,
   input  logic [NB_CHANNELS-1:0]             streamer_ctrl_ready_i,
   input  logic [NB_CHANNELS*FLAGS_WIDTH-1:0] streamer_flags_data_i,
   input  logic [NB_CHANNELS-1:0]             streamer_flags_valid_i,
   output logic [NB_CHANNELS-1:0]             streamer_flags_ready_o,
   output logic [NB_CHANNELS*FLAGS_WIDTH-1:0] flags_data_o,
   output logic [NB_CHANNELS-1:0]             flags_valid_o,
   input  logic [NB_CHANNELS-1:0]             flags_ready_i,
   output logic [NB_CHANNELS*CNT_W-1:0]       outstanding_o,
   output logic [NB_CHANNELS-1:0]             idle_o,
   output logic [NB_CHANNELS-1:0]             underflow_o
);
   for (genvar c = 0; c < NB_CHANNELS; c++) begin : g_ch
      logic             ctrl_push_rdy;
      logic             credit_ok;
      logic             ctrl_xfer, flags_xfer;
      logic [CNT_W-1:0] out_q, out_d;
      logic             uf_q, uf_d;

      assign credit_ok       = (out_q < CNT_W'(MAX_OUTSTANDING));
      assign ctrl_ready_o[c] = ctrl_push_rdy && credit_ok;
      assign ctrl_xfer       = ctrl_valid_i[c] && ctrl_ready_o[c];
      assign flags_xfer      = flags_valid_o[c] && flags_ready_i[c];

      // Credit gating is applied on the push valid so the FIFO only sees accepted words.
      hwpe_stream_streamer_queue_mc_fifo #(
         .WIDTH (CTRL_WIDTH),
         .DEPTH (FIFO_DEPTH)
      ) i_ctrl_fifo (
         .clk_i        (clk_i),
         .rst_i        (rst_i),
         .clear_i      (clear_i),
         .push_data_i  (ctrl_data_i[c*CTRL_WIDTH +: CTRL_WIDTH]),
         .push_valid_i (ctrl_valid_i[c] && credit_ok),
         .push_ready_o (ctrl_push_rdy),
         .pop_data_o   (streamer_ctrl_data_o[c*CTRL_WIDTH +: CTRL_WIDTH]),
         .pop_valid_o  (streamer_ctrl_valid_o[c]),
         .pop_ready_i  (streamer_ctrl_ready_i[c])
      );

      hwpe_stream_streamer_queue_mc_fifo #(
         .WIDTH (FLAGS_WIDTH),
         .DEPTH (FIFO_DEPTH)
      ) i_flags_fifo (
         .clk_i        (clk_i),
         .rst_i        (rst_i),
         .clear_i      (clear_i),
         .push_data_i  (streamer_flags_data_i[c*FLAGS_WIDTH +: FLAGS_WIDTH]),
         .push_valid_i (streamer_flags_valid_i[c]),
         .push_ready_o (streamer_flags_ready_o[c]),
         .pop_data_o   (flags_data_o[c*FLAGS_WIDTH +: FLAGS_WIDTH]),
         .pop_valid_o  (flags_valid_o[c]),
         .pop_ready_i  (flags_ready_i[c])
      );

      // A flags word delivered with no credit outstanding is a protocol error: it is
      // still delivered, the counter saturates at zero and the error is made sticky.
      always_comb begin
         out_d = out_q;
         uf_d  = uf_q;
         if (flags_xfer && (out_q == '0)) begin
            uf_d = 1'b1;
         end
         if (ctrl_xfer && !flags_xfer) begin
            out_d = out_q + CNT_W'(1);
         end else if (flags_xfer && !ctrl_xfer && (out_q != '0)) begin
            out_d = out_q - CNT_W'(1);
         end
      end

      always_ff @(posedge clk_i) begin
         if (rst_i || clear_i) begin
            out_q <= '0;
            uf_q  <= 1'b0;
         end else begin
            out_q <= out_d;
            uf_q  <= uf_d;
         end
      end

      assign outstanding_o[c*CNT_W +: CNT_W] = out_q;
      assign underflow_o[c]                  = uf_q;
      assign idle_o[c] = (out_q == '0) && !streamer_ctrl_valid_o[c] && !flags_valid_o[c];
   end
endmodule
